// File: rtl/execute_md.sv
// RV64IM execute stage: ID/EX register, operand forwarding, single-cycle ALU,
// branch target adder and an iterative shift-add / restoring-divide M unit.
module execute_md #(
    parameter int XLEN  = 64,
    parameter bit MD_EN = 1'b1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            FlushE,
    input  logic            StallE,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [3:0]      ALUControlD,
    input  logic            ALUSrcD,
    input  logic            MDValidD,
    input  logic [2:0]      MDOpD,
    input  logic [XLEN-1:0] read_data1,
    input  logic [XLEN-1:0] read_data2,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] ImmExtD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic [4:0]      RdD,
    input  logic [4:0]      Rs1D,
    input  logic [4:0]      Rs2D,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] ResultW,
    output logic [XLEN-1:0] ALUResultE,
    output logic            zeroE,
    output logic [XLEN-1:0] WriteDataE,
    output logic [XLEN-1:0] PCTargetE,
    output logic [4:0]      RdE,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E,
    output logic [XLEN-1:0] PCPlus4E,
    output logic            BusyE
);

    localparam int SW = $clog2(XLEN);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [XLEN-1:0] ZERO = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [SW-1:0] CNT_LAST = SW'(XLEN - 1);
    localparam logic [SW-1:0] CNT_ONE  = {{(SW-1){1'b0}}, 1'b1};

    // ID/EX pipeline register contents
    logic [XLEN-1:0] rd1_r;
    logic [XLEN-1:0] rd2_r;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] imm_r;
    logic [XLEN-1:0] pc_plus4_r;
    logic [4:0]      rd_r;
    logic [4:0]      rs1_r;
    logic [4:0]      rs2_r;
    logic [3:0]      alu_ctrl_r;
    logic            alu_src_r;
    logic            md_valid_r;
    logic [2:0]      md_op_r;

    // M unit state
    logic [1:0]      state_r;
    logic [SW-1:0]   cnt_r;
    logic [XLEN-1:0] hi_r;
    logic [XLEN-1:0] lo_r;
    logic [XLEN-1:0] mcand_r;
    logic [2:0]      lat_op_r;
    logic            neg_q_r;
    logic            neg_rem_r;
    logic [XLEN-1:0] md_result_r;

    logic [XLEN-1:0] src_a_s;
    logic [XLEN-1:0] fwd_b_s;
    logic [XLEN-1:0] src_b_s;
    logic [SW-1:0]   shamt_s;
    logic [XLEN-1:0] alu_res_s;
    logic            md_valid_s;

    logic            a_signed_s;
    logic            b_signed_s;
    logic            a_neg_s;
    logic            b_neg_s;
    logic [XLEN-1:0] a_mag_s;
    logic [XLEN-1:0] b_mag_s;
    logic            div_zero_s;
    logic            div_ovf_s;
    logic            fast_s;
    logic [XLEN-1:0] fast_res_s;

    logic [XLEN:0]     add_s;
    logic [XLEN:0]     shifted_s;
    logic              ge_s;
    logic [XLEN-1:0]   step_hi_s;
    logic [XLEN-1:0]   step_lo_s;
    logic [2*XLEN-1:0] prod_s;
    logic [2*XLEN-1:0] prod_fix_s;
    logic [XLEN-1:0]   quo_fix_s;
    logic [XLEN-1:0]   rem_fix_s;
    logic [XLEN-1:0]   final_s;

    // ID/EX register: reset and flush clear, flush beats stall
    always_ff @(posedge clock) begin
        if (!reset || FlushE) begin
            rd1_r      <= ZERO;
            rd2_r      <= ZERO;
            pc_r       <= ZERO;
            imm_r      <= ZERO;
            pc_plus4_r <= ZERO;
            rd_r       <= 5'd0;
            rs1_r      <= 5'd0;
            rs2_r      <= 5'd0;
            alu_ctrl_r <= 4'd0;
            alu_src_r  <= 1'b0;
            md_valid_r <= 1'b0;
            md_op_r    <= 3'd0;
        end else if (!StallE) begin
            rd1_r      <= read_data1;
            rd2_r      <= read_data2;
            pc_r       <= PCD;
            imm_r      <= ImmExtD;
            pc_plus4_r <= PCPlus4D;
            rd_r       <= RdD;
            rs1_r      <= Rs1D;
            rs2_r      <= Rs2D;
            alu_ctrl_r <= ALUControlD;
            alu_src_r  <= ALUSrcD;
            md_valid_r <= MDValidD;
            md_op_r    <= MDOpD;
        end
    end

    // Forwarding muxes and ALU operand select
    always_comb begin
        case (ForwardAE)
            2'b01:   src_a_s = ResultW;
            2'b10:   src_a_s = ALUResultM;
            default: src_a_s = rd1_r;
        endcase
        case (ForwardBE)
            2'b01:   fwd_b_s = ResultW;
            2'b10:   fwd_b_s = ALUResultM;
            default: fwd_b_s = rd2_r;
        endcase
        src_b_s = alu_src_r ? imm_r : fwd_b_s;
        shamt_s = src_b_s[SW-1:0];
    end

    // Single-cycle ALU
    always_comb begin
        case (alu_ctrl_r)
            4'd0:    alu_res_s = src_a_s + src_b_s;
            4'd1:    alu_res_s = src_a_s - src_b_s;
            4'd2:    alu_res_s = src_a_s & src_b_s;
            4'd3:    alu_res_s = src_a_s | src_b_s;
            4'd4:    alu_res_s = src_a_s ^ src_b_s;
            4'd5:    alu_res_s = {{(XLEN-1){1'b0}}, ($signed(src_a_s) < $signed(src_b_s))};
            4'd6:    alu_res_s = {{(XLEN-1){1'b0}}, (src_a_s < src_b_s)};
            4'd7:    alu_res_s = src_a_s << shamt_s;
            4'd8:    alu_res_s = src_a_s >> shamt_s;
            4'd9:    alu_res_s = $unsigned($signed(src_a_s) >>> shamt_s);
            default: alu_res_s = ZERO;
        endcase
    end

    // M op decode at start: operand signedness, magnitudes and the fast paths
    always_comb begin
        a_signed_s = (~md_op_r[2] & (md_op_r[1:0] != 2'b11)) | (md_op_r[2] & ~md_op_r[0]);
        b_signed_s = (~md_op_r[2] & ~md_op_r[1]) | (md_op_r[2] & ~md_op_r[0]);
        a_neg_s    = a_signed_s & src_a_s[XLEN-1];
        b_neg_s    = b_signed_s & fwd_b_s[XLEN-1];
        a_mag_s    = a_neg_s ? (ZERO - src_a_s) : src_a_s;
        b_mag_s    = b_neg_s ? (ZERO - fwd_b_s) : fwd_b_s;
        div_zero_s = md_op_r[2] & (fwd_b_s == ZERO);
        div_ovf_s  = md_op_r[2] & ~md_op_r[0] & (src_a_s == XMIN) & (fwd_b_s == ONES);
        fast_s     = div_zero_s | div_ovf_s;
        if (div_zero_s) begin
            fast_res_s = md_op_r[1] ? src_a_s : ONES;
        end else if (div_ovf_s) begin
            fast_res_s = md_op_r[1] ? ZERO : XMIN;
        end else begin
            fast_res_s = ZERO;
        end
    end

    // One iteration: shift-add multiply or restoring divide step
    always_comb begin
        add_s     = {1'b0, hi_r} + {1'b0, (lo_r[0] ? mcand_r : ZERO)};
        shifted_s = {hi_r, lo_r[XLEN-1]};
        // Remainder stays below the divisor, so the XLEN-bit difference is exact
        ge_s      = shifted_s[XLEN] | (shifted_s[XLEN-1:0] >= mcand_r);
        if (lat_op_r[2]) begin
            step_hi_s = ge_s ? (shifted_s[XLEN-1:0] - mcand_r) : shifted_s[XLEN-1:0];
            step_lo_s = {lo_r[XLEN-2:0], ge_s};
        end else begin
            step_hi_s = add_s[XLEN:1];
            step_lo_s = {add_s[0], lo_r[XLEN-1:1]};
        end
    end

    // Sign fix-up and result select after the final iteration
    always_comb begin
        prod_s     = {step_hi_s, step_lo_s};
        prod_fix_s = neg_q_r ? ({(2*XLEN){1'b0}} - prod_s) : prod_s;
        quo_fix_s  = neg_q_r ? (ZERO - step_lo_s) : step_lo_s;
        rem_fix_s  = neg_rem_r ? (ZERO - step_hi_s) : step_hi_s;
        case (lat_op_r)
            3'd0:       final_s = prod_fix_s[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:       final_s = prod_fix_s[2*XLEN-1:XLEN];
            3'd4, 3'd5: final_s = quo_fix_s;
            3'd6, 3'd7: final_s = rem_fix_s;
            default:    final_s = ZERO;
        endcase
    end

    assign md_valid_s = MD_EN & md_valid_r;

    // M unit FSM: IDLE -> BUSY (XLEN steps) -> DONE, or IDLE -> DONE on fast path
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {SW{1'b0}};
            hi_r        <= ZERO;
            lo_r        <= ZERO;
            mcand_r     <= ZERO;
            lat_op_r    <= 3'd0;
            neg_q_r     <= 1'b0;
            neg_rem_r   <= 1'b0;
            md_result_r <= ZERO;
        end else if (FlushE) begin
            state_r <= ST_IDLE;
            cnt_r   <= {SW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (md_valid_s) begin
                        lat_op_r  <= md_op_r;
                        neg_q_r   <= a_neg_s ^ b_neg_s;
                        neg_rem_r <= a_neg_s;
                        cnt_r     <= {SW{1'b0}};
                        if (fast_s) begin
                            md_result_r <= fast_res_s;
                            state_r     <= ST_DONE;
                        end else begin
                            hi_r    <= ZERO;
                            lo_r    <= a_mag_s;
                            mcand_r <= b_mag_s;
                            state_r <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    hi_r <= step_hi_s;
                    lo_r <= step_lo_s;
                    if (cnt_r == CNT_LAST) begin
                        md_result_r <= final_s;
                        cnt_r       <= {SW{1'b0}};
                        state_r     <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    if (!StallE) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= {SW{1'b0}};
                end
            endcase
        end
    end

    assign BusyE      = ((state_r == ST_IDLE) & md_valid_s) | (state_r == ST_BUSY);
    assign ALUResultE = (state_r == ST_DONE) ? md_result_r : alu_res_s;
    assign zeroE      = (ALUResultE == ZERO);
    assign WriteDataE = fwd_b_s;
    assign PCTargetE  = pc_r + imm_r;
    assign RdE        = rd_r;
    assign Rs1E       = rs1_r;
    assign Rs2E       = rs2_r;
    assign PCPlus4E   = pc_plus4_r;

endmodule

// File: tb/tb_execute_md.sv
// Randomized self-checking bench for execute_md (XLEN=64) against an arithmetic reference model.
module tb_execute_md;

    localparam int XLEN = 64;
    localparam logic [63:0] XMIN = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic            clock = 1'b0;
    logic            reset;
    logic            FlushE, StallE;
    logic [1:0]      ForwardAE, ForwardBE;
    logic [3:0]      ALUControlD;
    logic            ALUSrcD, MDValidD;
    logic [2:0]      MDOpD;
    logic [63:0]     read_data1, read_data2, PCD, ImmExtD, PCPlus4D;
    logic [4:0]      RdD, Rs1D, Rs2D;
    logic [63:0]     ALUResultM, ResultW;
    logic [63:0]     ALUResultE, WriteDataE, PCTargetE, PCPlus4E;
    logic            zeroE, BusyE;
    logic [4:0]      RdE, Rs1E, Rs2E;

    int vectors = 0;
    int miscompares = 0;

    execute_md #(.XLEN(XLEN), .MD_EN(1'b1)) dut (
        .clock(clock), .reset(reset), .FlushE(FlushE), .StallE(StallE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ALUControlD(ALUControlD),
        .ALUSrcD(ALUSrcD), .MDValidD(MDValidD), .MDOpD(MDOpD),
        .read_data1(read_data1), .read_data2(read_data2), .PCD(PCD),
        .ImmExtD(ImmExtD), .PCPlus4D(PCPlus4D), .RdD(RdD), .Rs1D(Rs1D), .Rs2D(Rs2D),
        .ALUResultM(ALUResultM), .ResultW(ResultW), .ALUResultE(ALUResultE),
        .zeroE(zeroE), .WriteDataE(WriteDataE), .PCTargetE(PCTargetE),
        .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E), .PCPlus4E(PCPlus4E), .BusyE(BusyE)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [63:0] alu_ref(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        longint sa;
        int sh;
        sa = a;
        sh = int'(b[5:0]);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            4'd6:    return (a < b) ? 64'd1 : 64'd0;
            4'd7:    return a << sh;
            4'd8:    return a >> sh;
            4'd9:    return sa >>> sh;
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [63:0] md_ref(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] xa, xb, p;
        longint sa, sb;
        sa = a;
        sb = b;
        xa = (op == 3'd3) ? {64'd0, a} : {{64{a[63]}}, a};
        xb = (op == 3'd2 || op == 3'd3) ? {64'd0, b} : {{64{b[63]}}, b};
        p = xa * xb;
        case (op)
            3'd0: return p[63:0];
            3'd1, 3'd2, 3'd3: return p[127:64];
            3'd4: begin
                if (b == 64'd0) return ONES;
                if (a == XMIN && b == ONES) return XMIN;
                return sa / sb;
            end
            3'd5: return (b == 64'd0) ? ONES : a / b;
            3'd6: begin
                if (b == 64'd0) return a;
                if (a == XMIN && b == ONES) return 64'd0;
                return sa % sb;
            end
            default: return (b == 64'd0) ? a : a % b;
        endcase
    endfunction

    task automatic bubble_inputs;
        FlushE = 1'b0; StallE = 1'b0; ForwardAE = 2'b00; ForwardBE = 2'b00;
        ALUControlD = 4'd0; ALUSrcD = 1'b0; MDValidD = 1'b0; MDOpD = 3'd0;
        read_data1 = 64'd0; read_data2 = 64'd0; PCD = 64'd0; ImmExtD = 64'd0; PCPlus4D = 64'd0;
        RdD = 5'd0; Rs1D = 5'd0; Rs2D = 5'd0; ALUResultM = 64'd0; ResultW = 64'd0;
    endtask

    // Load an M op into E; leaves StallE high as the hazard unit would
    task automatic start_md(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b, input bit fwd_a);
        bubble_inputs();
        MDValidD = 1'b1; MDOpD = op; RdD = 5'd9;
        ALUControlD = 4'($urandom_range(0, 9));
        read_data2 = b;
        if (fwd_a) begin
            read_data1 = rnd64(); ResultW = a; ForwardAE = 2'b01;
        end else begin
            read_data1 = a;
        end
        tick();
        StallE = 1'b1;
        MDValidD = 1'b0;
    endtask

    task automatic run_md(input string tag, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b, input bit fwd_a);
        int lat;
        int exp_lat;
        bit fast;
        start_md(op, a, b, fwd_a);
        lat = 0;
        while (BusyE === 1'b1 && lat < 200) begin
            lat++;
            tick();
        end
        fast = op[2] && (b == 64'd0 || (!op[0] && a == XMIN && b == ONES));
        exp_lat = fast ? 1 : XLEN + 1;
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_res"}, ALUResultE, md_ref(op, a, b));
        bubble_inputs();
        tick();
        check({tag, "_exit_busy"}, {63'd0, BusyE}, 64'd0);
        check({tag, "_exit_res"}, ALUResultE, 64'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_alu"}, ALUResultE, 64'd0);
        check({tag, "_zero"}, {63'd0, zeroE}, 64'd1);
        check({tag, "_pct"}, PCTargetE, 64'd0);
        check({tag, "_busy"}, {63'd0, BusyE}, 64'd0);
        check({tag, "_rd"}, {59'd0, RdE}, 64'd0);
        check({tag, "_pc4"}, PCPlus4E, 64'd0);
        check({tag, "_wd"}, WriteDataE, 64'd0);
    endtask

    initial begin
        logic [63:0] a, b, rd1, rd2, imm, pc, exp_a, exp_wd, exp_b, exp_r;
        logic [3:0]  op;
        logic [2:0]  mop;
        logic [1:0]  fa, fb;

        bubble_inputs();
        reset = 1'b0;
        tick();
        tick();
        check_reset_state("reset");
        reset = 1'b1;

        // Directed forwarding + immediate add
        read_data1 = 64'd5; ALUResultM = 64'd7; ForwardAE = 2'b10; ImmExtD = 64'd3;
        ALUSrcD = 1'b1; ALUControlD = 4'd0;
        tick();
        check("fwd_add", ALUResultE, 64'd10);
        check("fwd_add_zero", {63'd0, zeroE}, 64'd0);

        // Randomized ALU, forwarding and pass-through fields
        for (int i = 0; i < 40; i++) begin
            bubble_inputs();
            op = 4'($urandom_range(0, 11));
            rd1 = rnd64(); rd2 = ($urandom_range(0, 3) == 0) ? rd1 : rnd64();
            imm = ($urandom_range(0, 1) == 1) ? 64'($urandom_range(0, 70)) : rnd64();
            pc = rnd64();
            fa = 2'($urandom_range(0, 3)); fb = 2'($urandom_range(0, 3));
            read_data1 = rd1; read_data2 = rd2; ImmExtD = imm; PCD = pc; PCPlus4D = pc + 64'd4;
            ALUResultM = rnd64(); ResultW = rnd64(); ForwardAE = fa; ForwardBE = fb;
            ALUSrcD = 1'($urandom_range(0, 1)); ALUControlD = op;
            RdD = 5'($urandom_range(0, 31)); Rs1D = 5'($urandom_range(0, 31)); Rs2D = 5'($urandom_range(0, 31));
            tick();
            exp_a  = (fa == 2'b01) ? ResultW : (fa == 2'b10) ? ALUResultM : rd1;
            exp_wd = (fb == 2'b01) ? ResultW : (fb == 2'b10) ? ALUResultM : rd2;
            exp_b  = ALUSrcD ? imm : exp_wd;
            exp_r  = alu_ref(op, exp_a, exp_b);
            check($sformatf("alu_op%0d", op), ALUResultE, exp_r);
            check("alu_zero", {63'd0, zeroE}, {63'd0, (exp_r == 64'd0)});
            check("alu_wd", WriteDataE, exp_wd);
            check("alu_pct", PCTargetE, pc + imm);
            check("alu_pc4", PCPlus4E, pc + 64'd4);
            check("alu_idx", {49'd0, RdE, Rs1E, Rs2E}, {49'd0, RdD, Rs1D, Rs2D});
        end

        // Stall holds E; flush beats stall
        bubble_inputs();
        read_data1 = 64'd40; read_data2 = 64'd2; ALUControlD = 4'd1; RdD = 5'd17;
        tick();
        read_data1 = 64'd99; RdD = 5'd3; StallE = 1'b1;
        tick();
        check("stall_res", ALUResultE, 64'd38);
        check("stall_rd", {59'd0, RdE}, 64'd17);
        FlushE = 1'b1;
        tick();
        check("flush_res", ALUResultE, 64'd0);
        check("flush_rd", {59'd0, RdE}, 64'd0);

        // Directed M ops
        run_md("mul",     3'd0, 64'd6, ONES - 64'd6, 1'b0);
        run_md("mulhu",   3'd3, XMIN, 64'd4, 1'b0);
        run_md("div",     3'd4, ONES - 64'd6, 64'd2, 1'b0);
        run_md("rem",     3'd6, ONES - 64'd6, 64'd2, 1'b0);
        run_md("divu",    3'd5, 64'd100, 64'd7, 1'b0);
        run_md("remu",    3'd7, 64'd100, 64'd7, 1'b0);
        run_md("divu_z",  3'd5, 64'd5, 64'd0, 1'b0);
        run_md("rem_z",   3'd6, 64'd5, 64'd0, 1'b0);
        run_md("div_ovf", 3'd4, XMIN, ONES, 1'b0);
        run_md("rem_ovf", 3'd6, XMIN, ONES, 1'b0);
        run_md("mulh",    3'd1, ONES, XMIN, 1'b1);
        run_md("mulhsu",  3'd2, ONES, ONES, 1'b0);

        // Randomized M ops, with occasional special operands and forwarded rs1
        for (int i = 0; i < 24; i++) begin
            mop = 3'($urandom_range(0, 7));
            a = rnd64(); b = rnd64();
            case ($urandom_range(0, 7))
                0: b = 64'd0;
                1: begin a = XMIN; b = ONES; end
                2: begin a = 64'($urandom_range(0, 1000)); b = ONES - 64'($urandom_range(0, 20)); end
                3: b = 64'($urandom_range(1, 50));
                default: ;
            endcase
            run_md($sformatf("md_rand%0d_op%0d", i, mop), mop, a, b, 1'($urandom_range(0, 1)));
        end

        // Flush while BUSY at cnt=10
        start_md(3'd0, 64'd12345, 64'd678, 1'b0);
        for (int i = 0; i < 11; i++) tick();
        check("preflush_busy", {63'd0, BusyE}, 64'd1);
        FlushE = 1'b1;
        tick();
        check("flush_busy", {63'd0, BusyE}, 64'd0);
        check("flush_rd_md", {59'd0, RdE}, 64'd0);
        run_md("mul_after_flush", 3'd0, rnd64(), rnd64(), 1'b0);

        // Reset while BUSY
        start_md(3'd4, rnd64(), 64'd3, 1'b0);
        for (int i = 0; i < 20; i++) tick();
        read_data1 = 64'd77; PCD = 64'd100; ImmExtD = 64'd8; PCPlus4D = 64'd104; RdD = 5'd6;
        StallE = 1'b0;
        reset = 1'b0;
        tick();
        check_reset_state("reset_busy");
        bubble_inputs();
        reset = 1'b1;
        run_md("div_after_reset", 3'd4, ONES - 64'd99, 64'd9, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
